// File: rtl/sram_axi_bridge_if.sv
// AXI4-lite style bus between the SRAM-interface bridge and the memory system.
// Single-beat, 32-bit, one transaction outstanding.
interface sram_axi_bridge_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges a CPU's instruction and data SRAM-style ports onto a single AXI master.
// Data has priority; each port's done flag blocks reissue until the pipeline advances.
module sram_axi_bridge (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      inst_en,
  input  logic [31:0]               inst_addr,
  output logic [31:0]               inst_rdata,
  output logic                      inst_stall,
  input  logic                      data_en,
  input  logic [3:0]                data_wen,
  input  logic [31:0]               data_addr,
  input  logic [31:0]               data_wdata,
  output logic [31:0]               data_rdata,
  output logic                      data_stall,
  sram_axi_bridge_if.master         axi
);

  typedef enum logic [2:0] {
    StIdle,
    StIAr,
    StIR,
    StDAr,
    StDR,
    StDW,
    StDB
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_done_q, inst_done_d;
  logic        data_done_q, data_done_d;
  logic        inst_fin, data_fin;
  logic        pipe_adv;

  assign inst_stall = inst_en & ~inst_done_q;
  assign data_stall = data_en & ~data_done_q;
  assign pipe_adv   = ~inst_stall & ~data_stall;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_pend_d    = aw_pend_q;
    w_pend_d     = w_pend_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_fin     = 1'b0;
    data_fin     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (data_en && !data_done_q) begin
          addr_d  = data_addr;
          wstrb_d = data_wen;
          wdata_d = data_wdata;
          if (data_wen == 4'b0000) begin
            state_d = StDAr;
          end else begin
            state_d   = StDW;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end
        end else if (inst_en && !inst_done_q) begin
          addr_d  = inst_addr;
          state_d = StIAr;
        end
      end
      StIAr: begin
        if (axi.arready) state_d = StIR;
      end
      StIR: begin
        if (axi.rvalid) begin
          inst_rdata_d = axi.rdata;
          inst_fin     = 1'b1;
          state_d      = StIdle;
        end
      end
      StDAr: begin
        if (axi.arready) state_d = StDR;
      end
      StDR: begin
        if (axi.rvalid) begin
          data_rdata_d = axi.rdata;
          data_fin     = 1'b1;
          state_d      = StIdle;
        end
      end
      StDW: begin
        // AW and W retire independently; the response is only awaited once both are accepted.
        aw_pend_d = aw_pend_q & ~axi.awready;
        w_pend_d  = w_pend_q & ~axi.wready;
        if (!aw_pend_d && !w_pend_d) state_d = StDB;
      end
      StDB: begin
        if (axi.bvalid) begin
          data_fin = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flags drop together once neither port stalls, i.e. the pipeline has consumed both results.
    inst_done_d = pipe_adv ? 1'b0 : (inst_done_q | inst_fin);
    data_done_d = pipe_adv ? 1'b0 : (data_done_q | data_fin);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      aw_pend_q    <= 1'b0;
      w_pend_q     <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
    end
  end

  assign inst_rdata  = inst_rdata_q;
  assign data_rdata  = data_rdata_q;

  assign axi.araddr  = addr_q;
  assign axi.arvalid = (state_q == StIAr) || (state_q == StDAr);
  assign axi.rready  = (state_q == StIR) || (state_q == StDR);
  assign axi.awaddr  = addr_q;
  assign axi.awvalid = aw_pend_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = w_pend_q;
  assign axi.bready  = (state_q == StDB);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave by hand, cycle by cycle.
module tb_sram_axi_bridge;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;

  int checks = 0;
  int errors = 0;

  sram_axi_bridge_if axi ();

  sram_axi_bridge dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_stall (inst_stall),
    .data_en    (data_en),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_stall (data_stall),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    inst_en = 1'b0; inst_addr = 32'h0;
    data_en = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    axi.arready = 1'b0; axi.rdata = 32'h0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_arvalid", {31'h0, axi.arvalid}, 32'h0);
    chk("rst_awvalid", {31'h0, axi.awvalid}, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_araddr", axi.araddr, 32'h0);
    chk("rst_stalls", {30'h0, inst_stall, data_stall}, 32'h0);
    resetn = 1'b1;

    // Single fetch, arready immediate, rvalid two cycles after the AR handshake
    cyc(); inst_en = 1'b1; inst_addr = 32'hBFC0_0000; axi.arready = 1'b1; #1;
    chk("f_stall_req", {31'h0, inst_stall}, 32'h1);
    chk("f_arvalid_idle", {31'h0, axi.arvalid}, 32'h0);
    cyc(); #1;
    chk("f_arvalid", {31'h0, axi.arvalid}, 32'h1);
    chk("f_araddr", axi.araddr, 32'hBFC0_0000);
    cyc(); #1;
    chk("f_rready", {31'h0, axi.rready}, 32'h1);
    chk("f_arvalid_off", {31'h0, axi.arvalid}, 32'h0);
    chk("f_stall_wait", {31'h0, inst_stall}, 32'h1);
    cyc(); axi.rvalid = 1'b1; axi.rdata = 32'h3C08_0001; #1;
    chk("f_stall_rhs", {31'h0, inst_stall}, 32'h1);
    cyc(); axi.rvalid = 1'b0; #1;
    chk("f_stall_done", {31'h0, inst_stall}, 32'h0);
    chk("f_rdata", inst_rdata, 32'h3C08_0001);
    chk("f_rready_off", {31'h0, axi.rready}, 32'h0);
    inst_en = 1'b0;

    // Simultaneous fetch and load: data goes first
    cyc(); inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_1000; #1;
    chk("p_stalls_req", {30'h0, inst_stall, data_stall}, 32'h3);
    cyc(); #1;
    chk("p_araddr1", axi.araddr, 32'h8000_1000);
    chk("p_arvalid1", {31'h0, axi.arvalid}, 32'h1);
    cyc(); axi.rvalid = 1'b1; axi.rdata = 32'h1122_3344; #1;
    chk("p_rready1", {31'h0, axi.rready}, 32'h1);
    cyc(); axi.rvalid = 1'b0; #1;
    chk("p_stalls_mid", {30'h0, inst_stall, data_stall}, 32'h2);
    chk("p_data_rdata", data_rdata, 32'h1122_3344);
    chk("p_arvalid_gap", {31'h0, axi.arvalid}, 32'h0);
    cyc(); #1;
    chk("p_araddr2", axi.araddr, 32'hBFC0_0000);
    chk("p_arvalid2", {31'h0, axi.arvalid}, 32'h1);
    cyc(); axi.rvalid = 1'b1; axi.rdata = 32'h5566_7788; #1;
    chk("p_stalls_r2", {30'h0, inst_stall, data_stall}, 32'h2);
    cyc(); axi.rvalid = 1'b0; #1;
    chk("p_stalls_done", {30'h0, inst_stall, data_stall}, 32'h0);
    chk("p_inst_rdata", inst_rdata, 32'h5566_7788);
    inst_en = 1'b0; data_en = 1'b0;

    // Store with awready three cycles ahead of wready
    cyc(); data_en = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_0010;
    data_wdata = 32'hAABB_CCDD; #1;
    chk("s_stall_req", {31'h0, data_stall}, 32'h1);
    cyc(); #1;
    chk("s_valids", {30'h0, axi.awvalid, axi.wvalid}, 32'h3);
    chk("s_awaddr", axi.awaddr, 32'h8000_0010);
    chk("s_wdata", axi.wdata, 32'hAABB_CCDD);
    chk("s_wstrb", {28'h0, axi.wstrb}, 32'h3);
    chk("s_bready_early", {31'h0, axi.bready}, 32'h0);
    axi.awready = 1'b1;
    cyc(); axi.awready = 1'b0; #1;
    chk("s_valids_aw_done", {30'h0, axi.awvalid, axi.wvalid}, 32'h1);
    cyc(); #1;
    chk("s_valids_hold", {30'h0, axi.awvalid, axi.wvalid}, 32'h1);
    chk("s_bready_wait", {31'h0, axi.bready}, 32'h0);
    cyc(); axi.wready = 1'b1; #1;
    chk("s_wvalid_hs", {31'h0, axi.wvalid}, 32'h1);
    cyc(); axi.wready = 1'b0; axi.bvalid = 1'b1; #1;
    chk("s_wvalid_off", {31'h0, axi.wvalid}, 32'h0);
    chk("s_bready", {31'h0, axi.bready}, 32'h1);
    chk("s_stall_b", {31'h0, data_stall}, 32'h1);
    cyc(); axi.bvalid = 1'b0; #1;
    chk("s_stall_done", {31'h0, data_stall}, 32'h0);
    chk("s_bready_off", {31'h0, axi.bready}, 32'h0);
    chk("s_rdata_kept", data_rdata, 32'h1122_3344);
    data_en = 1'b0; data_wen = 4'h0;

    // arready withheld for ten cycles
    cyc(); axi.arready = 1'b0; inst_en = 1'b1; inst_addr = 32'h1FC0_0040;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk($sformatf("w_arvalid%0d", i), {31'h0, axi.arvalid}, 32'h1);
      chk($sformatf("w_araddr%0d", i), axi.araddr, 32'h1FC0_0040);
      chk($sformatf("w_rready%0d", i), {31'h0, axi.rready}, 32'h0);
    end
    axi.arready = 1'b1;

    // Reset while waiting in the read-data state
    cyc(); #1;
    chk("r_rready_pre", {31'h0, axi.rready}, 32'h1);
    resetn = 1'b0; #1;
    chk("r_rready", {31'h0, axi.rready}, 32'h0);
    chk("r_valids", {29'h0, axi.arvalid, axi.awvalid, axi.wvalid}, 32'h0);
    chk("r_bready", {31'h0, axi.bready}, 32'h0);
    chk("r_inst_rdata", inst_rdata, 32'h0);
    chk("r_data_rdata", data_rdata, 32'h0);
    cyc(); resetn = 1'b1; #1;
    chk("r_stalls", {30'h0, inst_stall, data_stall}, 32'h2);
    cyc(); #1;
    chk("r_arvalid", {31'h0, axi.arvalid}, 32'h1);
    chk("r_araddr", axi.araddr, 32'h1FC0_0040);
    cyc(); axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF; #1;
    cyc(); axi.rvalid = 1'b0; #1;
    chk("r_stall_done", {31'h0, inst_stall}, 32'h0);
    chk("r_fetch", inst_rdata, 32'hDEAD_BEEF);
    inst_en = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; no parameters; all AXI transfers single-beat, 32-bit word-aligned.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 inst_en  in  1  instruction fetch request; held with inst_addr stable while inst_stall=1.
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_rdata  out  32  fetched word, valid when inst_en=1 and inst_stall=0.
REQ-007 inst_stall  out  1  fetch not yet complete.
REQ-008 data_en  in  1  data access request; held with data_wen/data_addr/data_wdata stable while data_stall=1.
REQ-009 data_wen  in  4  byte write strobes; 0 = read, nonzero = write.
REQ-010 data_addr  in  32  data address.
REQ-011 data_wdata  in  32  store data.
REQ-012 data_rdata  out  32  load result, valid when data_en=1, data_wen=0 and data_stall=0.
REQ-013 data_stall  out  1  data access not yet complete.
REQ-014 araddr  out  32; arvalid out 1; arready in 1  AXI read-address channel.
REQ-015 rdata  in  32; rvalid in 1; rready out 1  AXI read-data channel.
REQ-016 awaddr  out  32; awvalid out 1; awready in 1  AXI write-address channel.
REQ-017 wdata  out  32; wstrb out 4; wvalid out 1; wready in 1  AXI write-data channel.
REQ-018 bvalid  in  1; bready out 1  AXI write-response channel.

Function
REQ-019 FSM states: IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B; at most one AXI transaction outstanding.
REQ-020 IDLE: data_en & ~data_done -> D_AR (wen=0) or D_W (wen!=0); else inst_en & ~inst_done -> I_AR; data has priority when both pending.
REQ-021 I_AR/D_AR: arvalid=1, araddr=registered request address; on arready -> I_R/D_R.
REQ-022 I_R/D_R: rready=1; on rvalid capture rdata into inst_rdata/data_rdata register, set inst_done/data_done, -> IDLE.
REQ-023 D_W: awvalid and wvalid asserted together from entry; each drops independently after its own handshake; both done (same or different cycles) -> D_B.
REQ-024 D_B: bready=1; on bvalid set data_done, -> IDLE; data_rdata unchanged by writes.
REQ-025 inst_stall = inst_en & ~inst_done; data_stall = data_en & ~data_done (combinational from flags).
REQ-026 Done flags hold while any stall is 1; both flags clear in the first cycle where inst_stall=0 and data_stall=0 (pipeline advanced).
REQ-027 A completed port SHALL NOT be reissued while its done flag is set.
REQ-028 Address/strobe/wdata latched on leaving IDLE; valids never drop before handshake; AXI outputs not depending on input combinationally.
REQ-029 Minimum latency per access: request cycle + 1 address cycle + 1 response cycle; stall falls the cycle after the response handshake.
REQ-030 Request deasserted mid-transaction: transaction completes, result discarded, flag cleared by REQ-026.

Reset
REQ-031 On resetn=0, asynchronously: state IDLE, all valid/ready outputs 0, inst_rdata=data_rdata=0, both done flags 0, address/data registers 0; reset mid-transaction abandons it.

Verification
REQ-032 Inst fetch 0xBFC00000, arready=1 immediately, rvalid 2 cycles later with 0x3C080001 -> inst_stall high until the cycle after the R handshake, then inst_rdata=0x3C080001.
REQ-033 inst_en and data_en (read 0x80001000) same cycle -> first AR is 0x80001000, then 0xBFC00000; both stalls low together only after the second completes.
REQ-034 Store wen=4'b0011, wdata 0xAABBCCDD to 0x80000010, awready 3 cycles before wready -> awvalid drops after its handshake, wvalid holds until wready, wstrb=0011, bready after both; data_stall low after bvalid.
REQ-035 arready held low 10 cycles -> arvalid and araddr stable all 10 cycles; no R-channel activity.
REQ-036 resetn pulsed low in I_R -> all valids/readies 0 immediately, rdata outputs 0, both stalls follow requests (1 if en high) after release.
